// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns PC, instruction MAR and IR, and runs a req/ack read
// against instruction memory with an ack timeout that substitutes a NOP and flags a fault.
module instruction_fetch_unit #(
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        DATA_W      = 16,
    parameter int unsigned        ACK_TIMEOUT = 15,
    parameter logic [DATA_W-1:0]  NOP_WORD    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signal_PC,
    input  logic              signal_PC_sel,
    input  logic              signal_I_MAR,
    input  logic              signal_read_I_mem,
    input  logic              signal_IR,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_busy,
    output logic              fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  mar_q, mar_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               req_q, req_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  buf_q, buf_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic               pend_q, pend_d;
    logic               fault_q, fault_d;

    logic [ADDR_W-1:0]  tgt;
    logic               ir_want;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mar_d   = mar_q;
        addr_d  = addr_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        pend_d  = pend_q;
        fault_d = fault_q;

        tgt     = signal_PC_sel ? jump_addr : pc_q;
        ir_want = pend_q | signal_IR;

        // MAR captures the target itself; PC always ends up one past it
        if (signal_I_MAR) begin
            mar_d = tgt;
        end
        if (signal_PC) begin
            pc_d = tgt + ADDR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (signal_read_I_mem) begin
                    addr_d  = mar_q;
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    buf_d   = mem_rdata;
                    req_d   = 1'b0;
                    state_d = S_HOLD;
                    if (ir_want) begin
                        instr_d = mem_rdata;
                        pend_d  = 1'b0;
                    end
                end else if (cnt_q == 8'(ACK_TIMEOUT)) begin
                    buf_d   = NOP_WORD;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    state_d = S_HOLD;
                    if (ir_want) begin
                        instr_d = NOP_WORD;
                        pend_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (signal_IR) begin
                        pend_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (signal_IR) begin
                    instr_d = buf_q;
                end
                // Back-to-back read: buf_q still feeds this cycle's IR load
                if (signal_read_I_mem) begin
                    addr_d  = mar_q;
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            mar_q   <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            cnt_q   <= 8'd0;
            buf_q   <= '0;
            instr_q <= '0;
            pend_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            pend_q  <= pend_d;
            fault_q <= fault_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_req     = req_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign fetch_busy  = (state_q == S_WAIT) | pend_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed strobe sequences, a simple memory responder,
// and a scoreboard that checks each new request address and each IR change.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        signal_PC, signal_PC_sel, signal_I_MAR, signal_read_I_mem, signal_IR;
    logic [7:0]  jump_addr;
    logic [7:0]  mem_addr;
    logic        mem_req;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instruction;
    logic [7:0]  pc;
    logic        fetch_busy;
    logic        fetch_fault;

    instruction_fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .signal_PC         (signal_PC),
        .signal_PC_sel     (signal_PC_sel),
        .signal_I_MAR      (signal_I_MAR),
        .signal_read_I_mem (signal_read_I_mem),
        .signal_IR         (signal_IR),
        .jump_addr         (jump_addr),
        .mem_addr          (mem_addr),
        .mem_req           (mem_req),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .instruction       (instruction),
        .pc                (pc),
        .fetch_busy        (fetch_busy),
        .fetch_fault       (fetch_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_addr_q[$];
    logic [15:0] exp_instr_q[$];

    logic [15:0] mem [256];
    logic        resp_en   = 1'b0;
    int          ack_delay = 0;
    int          wc        = 0;
    logic        resp_ack  = 1'b0;
    logic [15:0] resp_data = '0;
    logic        stray_ack = 1'b0;

    assign mem_ack   = resp_ack | stray_ack;
    assign mem_rdata = stray_ack ? 16'hBEEF : resp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (fetch_busy && n < 50) begin
            step();
            n++;
        end
        chk(name, fetch_busy, 1'b0);
    endtask

    // Memory responder: acks after ack_delay idle cycles of an outstanding request
    always @(posedge clk) begin
        #2;
        if (resp_en && mem_req && !resp_ack) begin
            if (wc == ack_delay) begin
                resp_ack  = 1'b1;
                resp_data = mem[mem_addr];
                wc        = 0;
            end else begin
                wc++;
            end
        end else begin
            resp_ack = 1'b0;
            if (!mem_req) wc = 0;
        end
    end

    // Scoreboard monitor
    logic        prev_req   = 1'b0;
    logic [15:0] prev_instr = '0;
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: addr %0h, expected no request", mem_addr);
            end else begin
                chk("req_addr", mem_addr, exp_addr_q.pop_front());
            end
        end
        if (instruction !== prev_instr) begin
            if (exp_instr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ir: instruction %0h, expected no change", instruction);
            end else begin
                chk("ir_value", instruction, exp_instr_q.pop_front());
            end
        end
        prev_req   = mem_req;
        prev_instr = instruction;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        int n;
        logic early;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0A21;
        mem[8'h3C] = 16'h1234;
        mem[8'hFF] = 16'hF800;

        reset = 1'b0;
        signal_PC = 0; signal_PC_sel = 0; signal_I_MAR = 0;
        signal_read_I_mem = 0; signal_IR = 0; jump_addr = 8'h00;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("rst_pc", pc, 8'h00);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_busy", fetch_busy, 1'b0);
        chk("rst_fault", fetch_fault, 1'b0);

        // Basic fetch: MAR=0, PC=1, ack after two empty wait cycles
        signal_I_MAR = 1; signal_PC = 1;
        step();
        signal_I_MAR = 0; signal_PC = 0;
        chk("t1_pc", pc, 8'h01);
        exp_addr_q.push_back(8'h00);
        resp_en = 1; ack_delay = 2;
        signal_read_I_mem = 1;
        step();
        signal_read_I_mem = 0;
        busy_cycles = 0;
        while (fetch_busy && busy_cycles < 20) begin
            busy_cycles++;
            step();
        end
        chk("t1_busy_cycles", busy_cycles, 3);
        exp_instr_q.push_back(16'h0A21);
        signal_IR = 1;
        step();
        signal_IR = 0;
        chk("t1_instr", instruction, 16'h0A21);

        // Jump: pc 0x10 -> target 0x3C
        signal_PC_sel = 1; jump_addr = 8'h0F; signal_PC = 1;
        step();
        chk("t2_pc_pre", pc, 8'h10);
        jump_addr = 8'h3C; signal_I_MAR = 1;
        step();
        signal_PC = 0; signal_I_MAR = 0; signal_PC_sel = 0;
        chk("t2_pc", pc, 8'h3D);
        exp_addr_q.push_back(8'h3C);
        ack_delay = 0;
        signal_read_I_mem = 1;
        step();
        signal_read_I_mem = 0;
        wait_idle("t2_done");
        exp_instr_q.push_back(16'h1234);
        signal_IR = 1;
        step();
        signal_IR = 0;
        chk("t2_instr", instruction, 16'h1234);

        // PC wrap: 0xFF -> 0x00, MAR keeps 0xFF
        signal_PC_sel = 1; jump_addr = 8'hFE; signal_PC = 1;
        step();
        signal_PC_sel = 0; signal_I_MAR = 1;
        step();
        signal_PC = 0; signal_I_MAR = 0;
        chk("t3_pc_wrap", pc, 8'h00);

        // IR strobe while waiting; a repeated read strobe in WAIT must be ignored
        exp_addr_q.push_back(8'hFF);
        ack_delay = 4;
        signal_read_I_mem = 1;
        step();
        signal_IR = 1;
        step();
        signal_IR = 0; signal_read_I_mem = 0;
        chk("t4_busy_pending", fetch_busy, 1'b1);
        exp_instr_q.push_back(16'hF800);
        early = 1'b0;
        n = 0;
        while (mem_req && n < 30) begin
            if (instruction !== 16'h1234) early = 1'b1;
            step();
            n++;
        end
        chk("t4_no_early_ir", early, 1'b0);
        chk("t4_instr", instruction, 16'hF800);
        chk("t4_busy_after", fetch_busy, 1'b0);
        step();
        chk("t4_single_req", mem_req, 1'b0);

        // Reset asserted mid-read
        exp_addr_q.push_back(8'hFF);
        ack_delay = 5;
        signal_read_I_mem = 1;
        step();
        signal_read_I_mem = 0;
        step();
        chk("t6_req_before", mem_req, 1'b1);
        exp_instr_q.push_back(16'h0000);
        reset = 1'b0;
        #1;
        chk("t6_req_drop", mem_req, 1'b0);
        chk("t6_pc", pc, 8'h00);
        chk("t6_instr", instruction, 16'h0000);
        chk("t6_busy", fetch_busy, 1'b0);
        chk("t6_addr", mem_addr, 8'h00);
        step();
        step();
        reset = 1'b1;
        stray_ack = 1'b1;
        step();
        stray_ack = 1'b0;
        chk("t6_stray_instr", instruction, 16'h0000);
        chk("t6_stray_req", mem_req, 1'b0);
        signal_IR = 1;
        step();
        signal_IR = 0;
        chk("t6_idle_ir", instruction, 16'h0000);

        // Load a real word, then a read that never gets acked
        exp_addr_q.push_back(8'h00);
        exp_instr_q.push_back(16'h0A21);
        ack_delay = 1;
        signal_read_I_mem = 1;
        step();
        signal_read_I_mem = 0;
        wait_idle("t5_pre_done");
        signal_IR = 1;
        step();
        signal_IR = 0;
        chk("t5_pre_instr", instruction, 16'h0A21);
        chk("t5_fault_before", fetch_fault, 1'b0);

        resp_en = 0;
        exp_addr_q.push_back(8'h00);
        signal_read_I_mem = 1;
        step();
        signal_read_I_mem = 0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        chk("t5_req_cycles", n, 16);
        chk("t5_fault", fetch_fault, 1'b1);
        chk("t5_busy", fetch_busy, 1'b0);
        exp_instr_q.push_back(16'h0000);
        signal_IR = 1;
        step();
        signal_IR = 0;
        chk("t5_nop", instruction, 16'h0000);
        step();
        chk("t5_fault_sticky", fetch_fault, 1'b1);

        step();
        chk("sb_addr_left", exp_addr_q.size(), 0);
        chk("sb_instr_left", exp_instr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
